// File: rtl/pixel_window_ctrl.sv
// Sequencer for the 3-tap pixel window buffer: shifts accepted pixels, injects an end-of-line pad.
// Optional macro EDGE_REPLICATE_EN: the pad repeats the last accepted pixel instead of zero.
module pixel_window_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int COL_W    = 10
) (
    input  logic             VGA_CLK,
    input  logic             RST,
    input  logic             pix_valid,
    input  logic             pix_sol,
    input  logic [7:0]       pix_data,
    output logic             in_ready,
    output logic [7:0]       buf_din,
    output logic             buf_shift,
    output logic             win_valid,
    output logic [COL_W-1:0] win_col,
    output logic             edge_l,
    output logic             edge_r,
    output logic             line_err
);

    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(H_ACTIVE - 1);
    localparam logic [COL_W-1:0] ONE      = COL_W'(1);

    state_t           state, state_nxt;
    logic [COL_W-1:0] in_col, in_col_nxt;
    logic [COL_W-1:0] win_col_nxt;
    logic             accept;
    logic             win_fire;
    logic             err_fire;
    logic [7:0]       pad;

`ifdef EDGE_REPLICATE_EN
    logic [7:0] last_pix;

    always_ff @(posedge VGA_CLK or posedge RST) begin
        if (RST)
            last_pix <= 8'h00;
        else if (accept)
            last_pix <= pix_data;
    end

    assign pad = last_pix;
`else
    assign pad = 8'h00;
`endif

    // No pixel is taken while reset is held, even though in_ready reads 1.
    assign in_ready  = (state != FLUSH);
    assign accept    = pix_valid & in_ready & ~RST;
    assign buf_shift = accept | (state == FLUSH);
    assign buf_din   = accept ? pix_data : ((state == FLUSH) ? pad : 8'h00);

    always_comb begin
        state_nxt   = state;
        in_col_nxt  = in_col;
        win_col_nxt = in_col;
        win_fire    = 1'b0;
        err_fire    = 1'b0;
        case (state)
            FLUSH: begin
                win_fire    = 1'b1;
                win_col_nxt = LAST_COL;
                in_col_nxt  = '0;
                state_nxt   = IDLE;
            end
            default: begin
                if (accept) begin
                    if (pix_sol) begin
                        // A sol outside IDLE aborts the partial line without a flush.
                        err_fire   = (state != IDLE);
                        in_col_nxt = ONE;
                        state_nxt  = (H_ACTIVE == 1) ? FLUSH : FILL;
                    end else if (state == IDLE) begin
                        err_fire = 1'b1;
                    end else begin
                        // This shift completes the window centred on the previous column.
                        win_fire    = 1'b1;
                        win_col_nxt = in_col - ONE;
                        in_col_nxt  = in_col + ONE;
                        state_nxt   = (in_col == LAST_COL) ? FLUSH : RUN;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge VGA_CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            in_col    <= '0;
            win_valid <= 1'b0;
            win_col   <= '0;
            edge_l    <= 1'b0;
            edge_r    <= 1'b0;
            line_err  <= 1'b0;
        end else begin
            state     <= state_nxt;
            in_col    <= in_col_nxt;
            win_valid <= win_fire;
            if (win_fire)
                win_col <= win_col_nxt;
            edge_l    <= win_fire && (win_col_nxt == '0);
            edge_r    <= win_fire && (win_col_nxt == LAST_COL);
            line_err  <= err_fire;
        end
    end

endmodule
